// File: rtl/muldiv_pkg.sv
// Shared op/state encodings and op-class helpers for muldiv_unit.
// Build macro MULDIV_MADD_EN turns op codes 6-9 into multiply-accumulate ops.
package muldiv_pkg;

    localparam int unsigned MD_ITER = 32;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MTHI  = 4'd4,
        OP_MTLO  = 4'd5,
        OP_MADD  = 4'd6,
        OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8,
        OP_MSUBU = 4'd9
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    // Ops that occupy the iterative datapath for the full CALC/FIX sequence.
    function automatic logic is_iter_op(input md_op_t op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_mul_op(input md_op_t op);
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_op(input md_op_t op);
        case (op)
            OP_MULT, OP_DIV, OP_MADD, OP_MSUB: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_acc_op(input md_op_t op);
        case (op)
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_sub_op(input md_op_t op);
        case (op)
            OP_MSUB, OP_MSUBU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational conditional two's-complement negate; gives magnitudes at issue
// and applies result sign correction at FIX.
module muldiv_signfix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_c_o
);

    always_comb begin
        res_c_o = neg_i ? (~val_i + W'(1)) : val_i;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Sequential multiply/divide unit owning HI/LO: radix-2 shift-add / restoring divide.
// Build macro MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulation into HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    md_state_t        state_q, state_d;
    md_op_t           op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    md_op_t           op_in;
    logic             sgn_in;
    logic [WIDTH-1:0] a_mag_c, b_mag_c, quo_c, rem_c;
    logic [W2-1:0]    prod_c, mul_res;
    logic [WIDTH:0]   mul_sum, div_diff;

    assign op_in  = md_op_t'(op);
    assign sgn_in = is_signed_op(op_in);

    muldiv_signfix #(.W(WIDTH)) u_abs_a (
        .val_i (a), .neg_i (sgn_in & a[WIDTH-1]), .res_c_o (a_mag_c)
    );
    muldiv_signfix #(.W(WIDTH)) u_abs_b (
        .val_i (b), .neg_i (sgn_in & b[WIDTH-1]), .res_c_o (b_mag_c)
    );
    muldiv_signfix #(.W(W2)) u_fix_prod (
        .val_i (acc_q), .neg_i (neg_res_q), .res_c_o (prod_c)
    );
    muldiv_signfix #(.W(WIDTH)) u_fix_quo (
        .val_i (acc_q[WIDTH-1:0]), .neg_i (neg_res_q), .res_c_o (quo_c)
    );
    muldiv_signfix #(.W(WIDTH)) u_fix_rem (
        .val_i (acc_q[W2-1:WIDTH]), .neg_i (neg_rem_q), .res_c_o (rem_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MULT;
            cnt_q     <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            a_q       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            a_q       <= a_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_d       = m_q;
        a_d       = a_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, m_q};
        div_diff  = acc_q[W2-1:WIDTH-1] - {1'b0, m_q};
`ifdef MULDIV_MADD_EN
        if (is_sub_op(op_q)) begin
            mul_res = {hi_q, lo_q} - prod_c;
        end else if (is_acc_op(op_q)) begin
            mul_res = {hi_q, lo_q} + prod_c;
        end else begin
            mul_res = prod_c;
        end
`else
        mul_res = prod_c;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_in == OP_MTHI) begin
                        hi_d = a;
                    end else if (op_in == OP_MTLO) begin
                        lo_d = a;
                    end else if (is_iter_op(op_in)) begin
                        state_d   = ST_CALC;
                        op_d      = op_in;
                        cnt_d     = '0;
                        a_d       = a;
                        neg_res_d = sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = sgn_in & a[WIDTH-1];
                        dz_d      = !is_mul_op(op_in) && (b == '0);
                        // Multiplier (or dividend) rides in the low half of the working register.
                        if (is_mul_op(op_in)) begin
                            acc_d = {WIDTH'(0), b_mag_c};
                            m_d   = a_mag_c;
                        end else begin
                            acc_d = {WIDTH'(0), a_mag_c};
                            m_d   = b_mag_c;
                        end
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
                if (is_mul_op(op_q)) begin
                    acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};
                end else if (!div_diff[WIDTH]) begin
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[W2-2:0], 1'b0};
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (is_mul_op(op_q)) begin
                    {hi_d, lo_d} = mul_res;
                end else if (dz_q) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = quo_c;
                    hi_d = rem_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
